softmax_normalizer: RTL and testbench
=====================================

SOFTMAX_NORMALIZER -- requirements
Module: softmax_normalizer

Interface
REQ-001 Parameter N, default 4, SHALL be the vector length in elements; legal range 2..8.
REQ-002 Parameter FRAC, default 8, SHALL be the output probability width, an unsigned fraction scaled by 2^FRAC.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark mant_in/exp_in as valid.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an element this cycle.
REQ-007 mant_in  input  3  SHALL be the pseudo-exponential mantissa from the pseudo_softmax stage.
REQ-008 exp_in  input  3  SHALL be the pseudo-exponential exponent from the pseudo_softmax stage.
REQ-009 out_valid  output  1  SHALL mark prob_out, idx_out and out_last as valid.
REQ-010 out_ready  input  1  SHALL be downstream acceptance of the current result.
REQ-011 prob_out  output  FRAC  SHALL be the normalised probability of element idx_out.
REQ-012 idx_out  output  3  SHALL be the element index, 0..N-1, in arrival order.
REQ-013 out_last  output  1  SHALL be 1 with the result for element N-1.

Function
REQ-014 Element value SHALL be V = (8 + mant_in) << exp_in, an 11-bit unsigned integer (range 8..1920).
REQ-015 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output handshake SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-016 The FSM SHALL have exactly three states: LOAD, DIV and OUT.
REQ-017 LOAD: in_ready=1 and out_valid=0; each transfer stores V in buffer slot cnt, adds V to SUM (width 11+ceil(log2 N) bits, no overflow possible) and increments cnt.
REQ-018 The transfer of element N-1 SHALL move the FSM to DIV with idx=0.
REQ-019 DIV: in_ready=0 and out_valid=0; a restoring divider SHALL compute Q = floor((V[idx] << FRAC) / SUM), producing one quotient bit per cycle, MSB first.
REQ-020 DIV SHALL last exactly FRAC cycles, then the FSM SHALL enter OUT with prob_out=Q; because N>=2 and V>=8, Q < 2^FRAC and no saturation is needed.
REQ-021 out_valid SHALL rise exactly FRAC rising edges after the edge that transferred element N-1.
REQ-022 OUT: out_valid=1; prob_out, idx_out and out_last SHALL hold stable while out_ready=0.
REQ-023 An output handshake with idx<N-1 SHALL increment idx and re-enter DIV; one with idx=N-1 SHALL clear SUM and cnt and re-enter LOAD.
REQ-024 in_ready SHALL be 0 outside LOAD; in_valid asserted in DIV or OUT SHALL be ignored, with no storage and no effect on SUM.
REQ-025 The block SHALL accept the first element of the next frame on the edge following the last output handshake, at the earliest.
REQ-026 Divider rounding SHALL be truncation; results SHALL not be renormalised, so sum(prob_out) <= 2^FRAC.

Reset
REQ-027 rst_n=0 SHALL immediately force state=LOAD, cnt=0, idx=0, SUM=0, in_ready=1 once released, out_valid=0, prob_out=0, idx_out=0, out_last=0.
REQ-028 Reset asserted mid-frame, in LOAD, DIV or OUT, SHALL discard all buffered elements and any partial quotient; the next frame starts from element 0.
REQ-029 Buffer contents need not be cleared by reset but SHALL never be output before being rewritten.

Verification
REQ-030 Uniform frame: N=4, FRAC=8, four elements each mant=0,exp=0 -> SUM=32; four results prob_out=64, idx 0..3, out_last only on idx 3.
REQ-031 Ramp frame: (m0,e0),(m0,e1),(m0,e2),(m0,e3) -> SUM=120; prob_out = 17, 34, 68, 136 in order.
REQ-032 Extreme frame: (m7,e7),(m0,e0),(m0,e0),(m0,e0) -> SUM=1944; prob_out = 252, 1, 1, 1.
REQ-033 Latency/backpressure: out_ready held 0 for 5 cycles per result -> out_valid rises exactly 8 edges after the 4th transfer; outputs stay stable while stalled; in_ready stays 0 until after the last handshake.
REQ-034 Reset mid-frame: pulse rst_n low after 2 transfers, then send the uniform frame -> outputs match REQ-030 exactly, with no stale element.
REQ-035 Ignored input: hold in_valid=1 with mant=7,exp=7 throughout DIV/OUT of the uniform frame -> results are unchanged and no extra element is counted.

Source files
------------

// File: rtl/softmax_normalizer.sv
// Normalises a frame of N pseudo-exponential values into FRAC-bit probabilities.
// Elements are buffered and summed, then each is divided by the sum with a serial restoring divider.
module softmax_normalizer #(
    parameter int N    = 4,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mant_in,
    input  logic [2:0]      exp_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FRAC-1:0] prob_out,
    output logic [2:0]      idx_out,
    output logic            out_last,
    output logic [1:0]      state_dbg
);

    // Handshake: a transfer happens on a rising edge only when valid and ready
    // are both 1; valid/payload are held by the source until that edge, and
    // ready never depends combinationally on valid.

    localparam int SW = 11 + $clog2(N);
    localparam int BW = $clog2(FRAC + 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [2:0]    LAST_IDX = 3'(N - 1);
    localparam logic [3:0]    LAST_CNT = 4'(N - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAC - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [SW-1:0]   rem_q, rem_d;
    logic [FRAC-1:0] quo_q, quo_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [FRAC-1:0] prob_q, prob_d;
    logic [10:0]     buf_q [8];
    logic [10:0]     buf_d [8];

    logic [10:0]     v_in;
    logic [SW:0]     rem_shift;
    logic [SW-1:0]   rem_diff;
    logic            q_bit;
    logic [FRAC-1:0] quo_next;

    always_comb begin
        v_in = {7'd0, 1'b1, mant_in} << exp_in;

        // The partial remainder is always below SUM, so the shifted value fits
        // in SW+1 bits and the difference, when taken, fits back into SW bits.
        rem_shift = {rem_q, 1'b0};
        q_bit     = rem_shift >= {1'b0, sum_q};
        rem_diff  = rem_shift[SW-1:0] - sum_q;
        quo_next  = (quo_q << 1) | {{(FRAC-1){1'b0}}, q_bit};

        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bit_d   = bit_q;
        prob_d  = prob_q;
        buf_d   = buf_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    buf_d[cnt_q[2:0]] = v_in;
                    sum_d             = sum_q + SW'(v_in);
                    cnt_d             = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        // Slot 0 was written on an earlier edge because N >= 2.
                        state_d = S_DIV;
                        idx_d   = 3'd0;
                        bit_d   = '0;
                        quo_d   = '0;
                        rem_d   = SW'(buf_q[0]);
                    end
                end
            end
            S_DIV: begin
                rem_d = q_bit ? rem_diff : rem_shift[SW-1:0];
                quo_d = quo_next;
                bit_d = bit_q + BW'(1);
                if (bit_q == LAST_BIT) begin
                    state_d = S_OUT;
                    prob_d  = quo_next;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_LOAD;
                        sum_d   = '0;
                        cnt_d   = 4'd0;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_DIV;
                        idx_d   = idx_q + 3'd1;
                        bit_d   = '0;
                        quo_d   = '0;
                        rem_d   = SW'(buf_q[idx_q + 3'd1]);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            sum_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            bit_q   <= '0;
            prob_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            bit_q   <= bit_d;
            prob_q  <= prob_d;
        end
    end

    // The buffer is never read before the current frame rewrites it, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign prob_out  = prob_q;
    assign idx_out   = idx_q;
    assign out_last  = (state_q == S_OUT) && (idx_q == LAST_IDX);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer: directed frames with literal results,
// plus randomized frames compared every cycle against a behavioural model.
module tb_softmax_normalizer;

    localparam int N    = 4;
    localparam int FRAC = 8;
    localparam int W    = FRAC + 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      mant_in;
    logic [2:0]      exp_in;
    logic            out_valid;
    logic            out_ready;
    logic [FRAC-1:0] prob_out;
    logic [2:0]      idx_out;
    logic            out_last;
    logic [1:0]      state_dbg;

    softmax_normalizer #(.N(N), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prob_out  (prob_out),
        .idx_out   (idx_out),
        .out_last  (out_last),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // behavioural model: frame buffer, per-frame division, expected result queue
    logic [W-1:0]    exp_q[$];
    logic [FRAC-1:0] got_q[$];
    int              vals[N];
    int              m_cnt   = 0;
    bit              m_busy  = 0;
    int              m_delay = 0;

    function automatic bit m_showing();
        return m_busy && (m_delay == 0);
    endfunction

    task automatic model_frame_done();
        longint s;
        longint p;
        s = 0;
        for (int i = 0; i < N; i++) s += vals[i];
        for (int i = 0; i < N; i++) begin
            p = (longint'(vals[i]) * (64'd1 << FRAC)) / s;
            exp_q.push_back({(i == N - 1) ? 1'b1 : 1'b0, 3'(i), FRAC'(p)});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt   = 0;
                m_busy  = 0;
                m_delay = 0;
                exp_q.delete();
            end else if (!m_busy) begin
                if (in_valid) begin
                    vals[m_cnt] = (8 + int'(mant_in)) << exp_in;
                    m_cnt++;
                    if (m_cnt == N) begin
                        model_frame_done();
                        m_busy  = 1;
                        m_delay = FRAC;
                    end
                end
            end else if (m_delay > 0) begin
                m_delay--;
            end else if (out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_busy = 0;
                    m_cnt  = 0;
                end else begin
                    m_delay = FRAC;
                end
            end
        end
    end

    // compare process: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_showing());
            if (m_showing() && exp_q.size() > 0) begin
                check("prob_out", prob_out, exp_q[0][FRAC-1:0]);
                check("idx_out", idx_out, exp_q[0][FRAC+2:FRAC]);
                check("out_last", out_last, exp_q[0][W-1]);
            end
            if (rst_n && out_valid && out_ready) got_q.push_back(prob_out);
        end
    end

    // driver tasks
    task automatic send_elem(input logic [2:0] m, input logic [2:0] e, input int gap);
        bit ok;
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
        in_valid = 1'b1;
        mant_in  = m;
        exp_in   = e;
        ok       = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic recv_frame(input int stall);
        bit seen;
        int st;
        for (int r = 0; r < N; r++) begin
            seen = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                check("recv_timeout", 0, 1);
                return;
            end
            st = (stall < 0) ? int'($urandom_range(0, 4)) : stall;
            @(posedge clk);
            #2;
            repeat (st) begin
                @(posedge clk);
                #2;
            end
            out_ready = 1'b1;
            if (r == N - 1) in_valid = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #2;
            out_ready = 1'b0;
        end
    endtask

    task automatic send_frame4(input logic [2:0] m0, input logic [2:0] e0,
                               input logic [2:0] m1, input logic [2:0] e1,
                               input logic [2:0] m2, input logic [2:0] e2,
                               input logic [2:0] m3, input logic [2:0] e3);
        send_elem(m0, e0, 0);
        send_elem(m1, e1, 0);
        send_elem(m2, e2, 0);
        send_elem(m3, e3, 0);
    endtask

    task automatic check_frame(input string name, input int p0, input int p1, input int p2, input int p3);
        check({name, "_count"}, got_q.size(), 4);
        if (got_q.size() == 4) begin
            check({name, "_p0"}, got_q[0], p0);
            check({name, "_p1"}, got_q[1], p1);
            check({name, "_p2"}, got_q[2], p2);
            check({name, "_p3"}, got_q[3], p3);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_prob_out", prob_out, 0);
        check("rst_idx_out", idx_out, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        got_q.delete();
    endtask

    int  edges;
    bit  seen_valid;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_in   = 3'd0;
        exp_in    = 3'd0;
        repeat (3) @(posedge clk);
        #2;
        pulse_reset();

        // uniform frame
        got_q.delete();
        send_frame4(0, 0, 0, 0, 0, 0, 0, 0);
        recv_frame(0);
        check_frame("uniform", 64, 64, 64, 64);

        // ramp frame
        got_q.delete();
        send_frame4(0, 0, 0, 1, 0, 2, 0, 3);
        recv_frame(0);
        check_frame("ramp", 17, 34, 68, 136);

        // extreme frame
        got_q.delete();
        send_frame4(7, 7, 0, 0, 0, 0, 0, 0);
        recv_frame(0);
        check_frame("extreme", 252, 1, 1, 1);

        // latency from last transfer to out_valid, then backpressure
        got_q.delete();
        send_frame4(0, 0, 0, 0, 0, 0, 0, 0);
        edges      = 0;
        seen_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen_valid = 1;
                break;
            end
            edges++;
        end
        check("latency_seen", seen_valid, 1);
        check("latency_edges", edges, FRAC);
        recv_frame(4);
        check_frame("stalled", 64, 64, 64, 64);

        // reset during LOAD, DIV and OUT, each followed by a clean uniform frame
        for (int phase = 0; phase < 3; phase++) begin
            send_elem(7, 7, 0);
            send_elem(7, 7, 0);
            if (phase > 0) begin
                send_elem(7, 7, 0);
                send_elem(5, 3, 0);
                repeat (3) @(posedge clk);
                #2;
            end
            if (phase == 2) begin
                for (int k = 0; k < 20 && !out_valid; k++) begin
                    @(posedge clk);
                    #2;
                end
            end
            pulse_reset();
            send_frame4(0, 0, 0, 0, 0, 0, 0, 0);
            recv_frame(1);
            check_frame($sformatf("rst_phase%0d", phase), 64, 64, 64, 64);
        end

        // input held valid throughout DIV/OUT must be ignored
        got_q.delete();
        send_frame4(0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        mant_in  = 3'd7;
        exp_in   = 3'd7;
        recv_frame(2);
        check_frame("ignored", 64, 64, 64, 64);
        got_q.delete();
        send_frame4(0, 0, 0, 1, 0, 2, 0, 3);
        recv_frame(0);
        check_frame("after_ignored", 17, 34, 68, 136);

        // randomized frames against the model
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < N; i++)
                send_elem(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
            recv_frame(-1);
        end

        repeat (5) @(posedge clk);
        #2;
        check("drain_exp_q", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
